// File: rtl/alu_cmd_issuer.sv
// Byte-serial command front end for an ALU: collects operands and a function code
// from an RX byte stream, fires the ALU once, and streams the result back out LSB first.
module alu_cmd_issuer #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               RST,
  input  logic [7:0]         RX_DATA,
  input  logic               RX_VALID,
  output logic [WIDTH-1:0]   A,
  output logic [WIDTH-1:0]   B,
  output logic [3:0]         ALU_FUN,
  output logic               ALU_EN,
  input  logic [2*WIDTH-1:0] ALU_OUT,
  input  logic               OUT_VALID,
  output logic [7:0]         TX_DATA,
  output logic               TX_VALID,
  input  logic               TX_READY,
  output logic               BUSY,
  output logic               ERR,
  output logic [2:0]         dbg_state
);

  localparam int NB  = WIDTH / 8;
  localparam int NRB = 2 * NB;
  localparam int BCW = (NRB > 1) ? $clog2(NRB) : 1;
  localparam int TW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NRB - 1);
  localparam logic [TW-1:0]  TC_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_OP  = 3'd1,
    GET_FUN = 3'd2,
    ISSUE   = 3'd3,
    WAIT    = 3'd4,
    SEND    = 3'd5
  } state_t;

  state_t             state, next_state;
  logic [BCW-1:0]     byte_cnt;
  logic [TW-1:0]      tcnt;
  logic [2*WIDTH-1:0] result;
  logic               err_q;
  logic [7:0]         tx_byte;

  logic byte_clr, byte_inc, op_load, fun_load;
  logic tcnt_clr, tcnt_inc, capture, err_set;

  // TX handshake: a byte moves on a rising edge where TX_VALID && TX_READY; while
  // TX_READY is low the same byte stays on TX_DATA and TX_VALID stays high.
  assign ALU_EN    = (state == ISSUE);
  assign BUSY      = (state != IDLE);
  assign TX_VALID  = (state == SEND);
  assign TX_DATA   = TX_VALID ? tx_byte : 8'h00;
  assign ERR       = err_q;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    byte_clr   = 1'b0;
    byte_inc   = 1'b0;
    op_load    = 1'b0;
    fun_load   = 1'b0;
    tcnt_clr   = 1'b0;
    tcnt_inc   = 1'b0;
    capture    = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        if (RX_VALID) begin
          if (RX_DATA == 8'hCC) begin
            next_state = GET_OP;
            byte_clr   = 1'b1;
          end else if (RX_DATA == 8'hDD) begin
            next_state = GET_FUN;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      GET_OP: begin
        if (RX_VALID) begin
          op_load = 1'b1;
          if (byte_cnt == LAST_BYTE) begin
            next_state = GET_FUN;
            byte_clr   = 1'b1;
          end else begin
            byte_inc = 1'b1;
          end
        end
      end
      GET_FUN: begin
        if (RX_VALID) begin
          fun_load   = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        err_set    = RX_VALID;
        tcnt_clr   = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        err_set = RX_VALID;
        // A result arriving on the expiry cycle still counts as a result.
        if (OUT_VALID) begin
          capture    = 1'b1;
          byte_clr   = 1'b1;
          next_state = SEND;
        end else if (tcnt == TC_LAST) begin
          err_set    = 1'b1;
          next_state = IDLE;
        end else begin
          tcnt_inc = 1'b1;
        end
      end
      SEND: begin
        err_set = RX_VALID;
        if (TX_READY) begin
          if (byte_cnt == LAST_BYTE) begin
            byte_clr   = 1'b1;
            next_state = IDLE;
          end else begin
            byte_inc = 1'b1;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      A        <= '0;
      B        <= '0;
      ALU_FUN  <= '0;
      result   <= '0;
      byte_cnt <= '0;
      tcnt     <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= err_set;
      if (byte_clr)      byte_cnt <= '0;
      else if (byte_inc) byte_cnt <= byte_cnt + 1'b1;
      if (tcnt_clr)      tcnt <= '0;
      else if (tcnt_inc) tcnt <= tcnt + 1'b1;
      if (capture)  result  <= ALU_OUT;
      if (fun_load) ALU_FUN <= RX_DATA[3:0];
      // Operand bytes arrive A first, then B, each least significant byte first.
      if (op_load) begin
        for (int i = 0; i < NB; i++) begin
          if (byte_cnt == BCW'(i))      A[i*8 +: 8] <= RX_DATA;
          if (byte_cnt == BCW'(NB + i)) B[i*8 +: 8] <= RX_DATA;
        end
      end
    end
  end

  always_comb begin
    tx_byte = 8'h00;
    for (int i = 0; i < NRB; i++) begin
      if (byte_cnt == BCW'(i)) tx_byte = result[i*8 +: 8];
    end
  end

endmodule
